// File: rtl/burst_fill_responder.sv
// Memory-side responder for the cache fill port: fetches a 4-word line from a
// pipelined word-wide backend and streams it back, or forwards a single-word write.
module burst_fill_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_OUTST  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] sdram_addr,
    input  logic                  sdram_req,
    input  logic                  sdram_rw,
    input  logic [DATA_WIDTH-1:0] data_to_sdram,
    output logic                  sdram_fill,
    output logic [DATA_WIDTH-1:0] data_from_sdram,
    output logic                  busy,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD_FETCH,
        RD_STREAM,
        WR_ISSUE,
        HOLD
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-2:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [2:0]              r_issue_cnt;
    logic [2:0]              r_recv_cnt;
    logic [1:0]              r_strm_cnt;
    logic                    r_wr_pend;
    logic                    r_fill;
    logic [DATA_WIDTH-1:0]   r_rdata_out;
    logic [DATA_WIDTH-1:0]   r_buf [0:3];

    logic [2:0]              w_outst;
    logic [1:0]              w_word_sel;
    logic                    w_buf_we;
    logic                    w_mem_req;
    logic                    w_mem_we;
    logic [ADDR_WIDTH-1:0]   w_mem_addr;
    logic [DATA_WIDTH-1:0]   w_mem_wdata;
    logic                    w_unused;

    assign w_unused   = sdram_addr[0];
    assign w_outst    = r_issue_cnt - r_recv_cnt;
    // Word order wraps within the line starting at the requested word.
    assign w_word_sel = r_addr[1:0] + r_issue_cnt[1:0];
    assign w_buf_we   = (r_state == RD_FETCH) && mem_rvalid;

    always_comb begin
        w_state_next = r_state;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_addr   = '0;
        w_mem_wdata  = '0;
        case (r_state)
            IDLE: begin
                if (sdram_req) begin
                    w_state_next = sdram_rw ? RD_FETCH : WR_ISSUE;
                end
            end
            RD_FETCH: begin
                if ((r_issue_cnt < 3'd4) && (w_outst < 3'(MAX_OUTST))) begin
                    w_mem_req  = 1'b1;
                    w_mem_addr = {r_addr[ADDR_WIDTH-2:2], w_word_sel, 1'b0};
                end
                if (mem_rvalid && (r_recv_cnt == 3'd3)) begin
                    w_state_next = RD_STREAM;
                end
            end
            RD_STREAM: begin
                if (r_strm_cnt == 2'd3) begin
                    w_state_next = HOLD;
                end
            end
            WR_ISSUE: begin
                if (!r_wr_pend) begin
                    w_mem_req   = 1'b1;
                    w_mem_we    = 1'b1;
                    w_mem_addr  = {r_addr, 1'b0};
                    w_mem_wdata = r_wdata;
                end else begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                // Only a dropped request re-arms IDLE, so a served request is never taken twice.
                if (!sdram_req) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_strm_cnt  <= '0;
            r_wr_pend   <= 1'b0;
            r_fill      <= 1'b0;
            r_rdata_out <= '0;
        end else begin
            r_state <= w_state_next;
            r_fill  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (sdram_req) begin
                        r_addr      <= sdram_addr[ADDR_WIDTH-1:1];
                        r_wdata     <= data_to_sdram;
                        r_issue_cnt <= '0;
                        r_recv_cnt  <= '0;
                        r_strm_cnt  <= '0;
                        r_wr_pend   <= 1'b0;
                    end
                end
                RD_FETCH: begin
                    if (w_mem_req && mem_ack) begin
                        r_issue_cnt <= r_issue_cnt + 3'd1;
                    end
                    if (mem_rvalid) begin
                        r_recv_cnt <= r_recv_cnt + 3'd1;
                    end
                end
                RD_STREAM: begin
                    r_fill      <= (r_strm_cnt == 2'd0);
                    r_rdata_out <= r_buf[r_strm_cnt];
                    r_strm_cnt  <= r_strm_cnt + 2'd1;
                end
                WR_ISSUE: begin
                    if (r_wr_pend) begin
                        r_fill <= 1'b1;
                    end else if (mem_ack) begin
                        r_wr_pend <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            r_buf[r_recv_cnt[1:0]] <= mem_rdata;
        end
    end

    assign sdram_fill      = r_fill;
    assign data_from_sdram = r_rdata_out;
    assign busy            = (r_state != IDLE);
    assign mem_req         = w_mem_req;
    assign mem_we          = w_mem_we;
    assign mem_addr        = w_mem_addr;
    assign mem_wdata       = w_mem_wdata;

endmodule

// File: tb/tb_burst_fill_responder.sv
// Directed bench for burst_fill_responder: behavioural backend plus scoreboard
// queues for backend commands and the returned fill stream.
module tb_burst_fill_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] sdram_addr;
    logic        sdram_req;
    logic        sdram_rw;
    logic [15:0] data_to_sdram;
    logic        sdram_fill;
    logic [15:0] data_from_sdram;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;

    always #5 clk = ~clk;

    burst_fill_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(16), .MAX_OUTST(4)) dut (
        .clk(clk), .reset(reset), .sdram_addr(sdram_addr), .sdram_req(sdram_req),
        .sdram_rw(sdram_rw), .data_to_sdram(data_to_sdram), .sdram_fill(sdram_fill),
        .data_from_sdram(data_from_sdram), .busy(busy), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard queues
    logic [31:0] q_cmd_addr[$];
    bit          q_cmd_we[$];
    logic [15:0] q_cmd_wdata[$];
    logic [15:0] q_data[$];
    bit          q_kind[$];

    // Backend model
    int          cyc_p = 0;
    int          ack_wait = 0, rv_delay = 1, rv_gap = 0;
    int          wait_cnt = 0, last_rv = -100, outst = 0;
    int          n_wr_cmds = 0, rv_total = 0, last_ack_cyc = 0;
    int          rd_ready[$];
    logic [15:0] rd_data[$];

    always @(posedge clk) cyc_p++;

    always @(negedge clk) begin
        logic [15:0] wd;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (reset) begin
            rd_ready.delete();
            rd_data.delete();
            wait_cnt = 0;
            outst    = 0;
        end else begin
            if (rd_ready.size() > 0 && rd_ready[0] <= cyc_p && cyc_p > last_rv + rv_gap) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd_data.pop_front();
                void'(rd_ready.pop_front());
                last_rv = cyc_p;
                rv_total++;
                outst--;
            end
            if (mem_req) begin
                if (wait_cnt < ack_wait) begin
                    wait_cnt++;
                end else begin
                    mem_ack      = 1'b1;
                    wait_cnt     = 0;
                    last_ack_cyc = cyc_p;
                    if (q_cmd_addr.size() == 0) begin
                        chk("spurious_cmd", 32'(mem_addr), 32'hFFFF_FFFF);
                    end else begin
                        chk("cmd_addr", mem_addr, q_cmd_addr.pop_front());
                        chk("cmd_we", 32'(mem_we), 32'(q_cmd_we.pop_front()));
                        wd = q_cmd_wdata.pop_front();
                        if (mem_we) chk("cmd_wdata", 32'(mem_wdata), 32'(wd));
                    end
                    if (mem_we) begin
                        n_wr_cmds++;
                    end else begin
                        rd_ready.push_back(cyc_p + rv_delay);
                        rd_data.push_back(mem_addr[16:1]);
                        outst++;
                        chk("outstanding_le_max", 32'(outst <= 4), 32'd1);
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Fill-stream monitor and busy gap tracker
    int rem = 0, n_fill = 0, last_fill_cyc = 0, idle_run = 0, last_gap = 0;

    always @(negedge clk) begin
        if (reset) begin
            rem      = 0;
            idle_run = 0;
        end else begin
            if (!busy) idle_run++;
            else begin
                if (idle_run > 0) last_gap = idle_run;
                idle_run = 0;
            end
            if (sdram_fill) begin
                n_fill++;
                last_fill_cyc = cyc_p;
                if (rem != 0) chk("fill_mid_stream", 32'd1, 32'd0);
                if (q_kind.size() == 0) chk("spurious_fill", 32'd1, 32'd0);
                else if (q_kind.pop_front()) begin
                    chk("data_word0", 32'(data_from_sdram), 32'(q_data.pop_front()));
                    rem = 3;
                end
            end else if (rem > 0) begin
                chk("data_stream", 32'(data_from_sdram), 32'(q_data.pop_front()));
                rem--;
            end
        end
    end

    // One request, from the current negedge+1 until busy drops after req is released.
    task automatic txn(input logic [31:0] addr, input bit rw, input logic [15:0] wd,
                       input int hold_cycles, output int lat);
        int f0;
        logic [1:0]  w;
        logic [31:0] a;
        if (rw) begin
            for (int i = 0; i < 4; i++) begin
                w = addr[2:1] + 2'(i);
                a = {addr[31:3], w, 1'b0};
                q_cmd_addr.push_back(a);
                q_cmd_we.push_back(1'b0);
                q_cmd_wdata.push_back(16'h0);
                q_data.push_back(a[16:1]);
            end
        end else begin
            q_cmd_addr.push_back({addr[31:1], 1'b0});
            q_cmd_we.push_back(1'b1);
            q_cmd_wdata.push_back(wd);
        end
        q_kind.push_back(rw);
        $display("TXN start %s addr=0x%08h wdata=0x%04h t=%0t", rw ? "READ " : "WRITE", addr, wd, $time);
        sdram_req     = 1'b1;
        sdram_addr    = addr;
        sdram_rw      = rw;
        data_to_sdram = wd;
        f0  = n_fill;
        lat = 0;
        while (n_fill == f0 && lat < 300) begin
            @(negedge clk); #1;
            lat++;
            if (lat == 1) begin
                chk("busy_after_accept", 32'(busy), 32'd1);
                sdram_addr    = ~addr;
                sdram_rw      = ~rw;
                data_to_sdram = ~wd;
            end
        end
        chk("fill_seen", 32'(n_fill != f0), 32'd1);
        if (rw) repeat (3) begin @(negedge clk); #1; end
        repeat (hold_cycles) begin @(negedge clk); #1; end
        @(negedge clk); #1;
        sdram_req = 1'b0;
        for (int i = 0; i < 20 && busy; i++) begin @(negedge clk); #1; end
        chk("busy_drops", 32'(busy), 32'd0);
        $display("TXN done  %s addr=0x%08h fill_latency=%0d t=%0t", rw ? "READ " : "WRITE", addr, lat, $time);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_fill"},   32'(sdram_fill), 32'd0);
        chk({pfx, "_rdata"},  32'(data_from_sdram), 32'd0);
        chk({pfx, "_busy"},   32'(busy), 32'd0);
        chk({pfx, "_memreq"}, 32'(mem_req), 32'd0);
        chk({pfx, "_memwe"},  32'(mem_we), 32'd0);
        chk({pfx, "_maddr"},  mem_addr, 32'd0);
        chk({pfx, "_mwdata"}, 32'(mem_wdata), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, base, wr0, f0;
        reset = 1'b1; sdram_req = 1'b0; sdram_rw = 1'b0;
        sdram_addr = '0; data_to_sdram = '0;
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk); #1;

        // 1: read from start word 0, zero-wait ack, rvalid one cycle after ack
        ack_wait = 0; rv_delay = 1; rv_gap = 0;
        txn(32'h0000_1230, 1'b1, 16'h0, 0, lat);
        chk("rd_fill_latency_N1", 32'(lat), 32'd7);

        // 2: read starting at word 2, wrap order
        txn(32'h0000_1234, 1'b1, 16'h0, 0, lat);

        // 3: stalling backend, gaps between rvalids
        ack_wait = 3; rv_delay = 1; rv_gap = 2;
        txn(32'h0000_567E, 1'b1, 16'h0, 0, lat);

        // 4: write with delayed ack, req held high well after fill
        ack_wait = 2; rv_gap = 0;
        wr0 = n_wr_cmds;
        f0  = n_fill;
        txn(32'h0000_0040, 1'b0, 16'hBEEF, 5, lat);
        chk("wr_single_cmd", 32'(n_wr_cmds - wr0), 32'd1);
        chk("wr_single_fill", 32'(n_fill - f0), 32'd1);
        chk("wr_fill_after_ack", 32'(last_fill_cyc - last_ack_cyc), 32'd2);

        // 5: reset during fetch after two returned words
        ack_wait = 0; rv_delay = 2; rv_gap = 2;
        for (int i = 0; i < 4; i++) begin
            q_cmd_addr.push_back(32'h0000_2000 + 32'(2 * i));
            q_cmd_we.push_back(1'b0);
            q_cmd_wdata.push_back(16'h0);
        end
        $display("TXN start READ  addr=0x00002000 (aborted by reset) t=%0t", $time);
        base = rv_total;
        sdram_req = 1'b1; sdram_rw = 1'b1; sdram_addr = 32'h0000_2000;
        for (int i = 0; i < 50 && rv_total < base + 2; i++) begin @(negedge clk); #1; end
        chk("rv_two_before_reset", 32'(rv_total - base), 32'd2);
        @(negedge clk); #1;
        reset = 1'b1; sdram_req = 1'b0;
        @(negedge clk); #1;
        chk_all_zero("midop_reset");
        q_cmd_addr.delete(); q_cmd_we.delete(); q_cmd_wdata.delete();
        q_data.delete(); q_kind.delete();
        reset = 1'b0;
        @(negedge clk); #1;
        rv_delay = 1; rv_gap = 0;
        txn(32'h0000_0100, 1'b1, 16'h0, 0, lat);

        // 6: back-to-back read then write
        f0 = n_fill;
        txn(32'h0000_3002, 1'b1, 16'h0, 0, lat);
        txn(32'h0000_3008, 1'b0, 16'h1234, 0, lat);
        chk("b2b_idle_gap", 32'(last_gap), 32'd1);
        chk("b2b_two_fills", 32'(n_fill - f0), 32'd2);
        chk("sb_data_drained", 32'(q_data.size()), 32'd0);
        chk("sb_cmds_drained", 32'(q_cmd_addr.size()), 32'd0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
